// File: rtl/datapath_controller_if.sv
// Handshake/control bundle between the instruction controller and the datapath.
// The controller owns the master side; the datapath (or a bench) owns the slave side.
interface datapath_controller_if;
    logic        run;
    logic [31:0] IR;
    logic [3:0]  SF;
    logic        AS, PC_Sel, K_Sel, IL, SL, C0, MW, RW;
    logic [1:0]  DS, PS;
    logic [4:0]  FS, DA, SA, SB;
    logic [63:0] K;
    logic [2:0]  state;
    logic        halted, illegal;

    modport master (
        input  run, IR, SF,
        output AS, PC_Sel, K_Sel, IL, SL, C0, MW, RW,
        output DS, PS, FS, DA, SA, SB, K, state, halted, illegal
    );

    modport slave (
        output run, IR, SF,
        input  AS, PC_Sel, K_Sel, IL, SL, C0, MW, RW,
        input  DS, PS, FS, DA, SA, SB, K, state, halted, illegal
    );
endinterface

// File: rtl/datapath_controller.sv
// Multi-cycle instruction controller: IDLE/FETCH/DECODE/EXEC/MEM/HALT sequencer
// producing registered datapath control words.
module datapath_controller #(
    parameter logic [1:0] PS_HOLD = 2'b00,
    parameter logic [1:0] PS_INC  = 2'b01,
    parameter logic [1:0] PS_LOAD = 2'b10,
    parameter logic [1:0] PS_ADD  = 2'b11,
    parameter logic [4:0] FS_ADD  = 5'b01000,
    parameter int         Z_BIT   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    datapath_controller_if.master        bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, MEM = 3'd4, HALT = 3'd5
    } state_t;

    typedef struct packed {
        logic       asel, pc_sel, k_sel, il, sl, c0, mw, rw;
        logic [1:0] ds, ps;
        logic [4:0] fs, da, sa, sb;
        logic       halted, illegal;
    } ctl_t;

    localparam logic [5:0] OP_ALU = 6'b000000, OP_ADDI = 6'b000001, OP_LDR = 6'b000010,
                           OP_STR = 6'b000011, OP_B    = 6'b000100, OP_BEQ  = 6'b000101,
                           OP_BR  = 6'b000110, OP_HALT = 6'b111111;

    state_t state;
    ctl_t   ctl;

    function automatic state_t next_state(state_t s, logic run, logic [5:0] op);
        case (s)
            IDLE:    next_state = run ? FETCH : IDLE;
            FETCH:   next_state = DECODE;
            DECODE:  next_state = run ? EXEC : IDLE;
            EXEC:    next_state = (op == OP_LDR) ? MEM : (op == OP_HALT) ? HALT : FETCH;
            MEM:     next_state = FETCH;
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    endfunction

    // Control word for the state being entered; IR/SF are stable across the edge
    // that enters EXEC because IR was loaded in FETCH and SF by the previous EXEC.
    function automatic ctl_t decode(state_t s, logic [31:0] ir, logic [3:0] sf);
        ctl_t c;
        c    = '0;
        c.ps = PS_HOLD;
        c.fs = FS_ADD;
        c.da = ir[25:21];
        c.sa = ir[20:16];
        c.sb = ir[15:11];
        case (s)
            FETCH:  begin c.asel = 1'b1; c.ds = 2'b11; c.il = 1'b1; end
            DECODE: c.ps = PS_INC;
            EXEC: begin
                case (ir[31:26])
                    OP_ALU:  begin c.fs = ir[10:6]; c.rw = 1'b1; c.sl = 1'b1; end
                    OP_ADDI: begin c.k_sel = 1'b1; c.rw = 1'b1; c.sl = 1'b1; end
                    OP_LDR:  begin c.k_sel = 1'b1; c.ds = 2'b11; end
                    OP_STR:  begin c.k_sel = 1'b1; c.sb = ir[25:21]; c.ds = 2'b10; c.mw = 1'b1; end
                    OP_B:    begin c.pc_sel = 1'b1; c.ps = PS_ADD; end
                    OP_BEQ:  begin c.pc_sel = 1'b1; c.ps = sf[Z_BIT] ? PS_ADD : PS_HOLD; end
                    OP_BR:   c.ps = PS_LOAD;
                    OP_HALT: ;
                    default: c.illegal = 1'b1;
                endcase
            end
            MEM:    begin c.k_sel = 1'b1; c.ds = 2'b11; c.rw = 1'b1; end
            HALT:   c.halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ctl     <= '0;
            ctl.ps  <= PS_HOLD;
            ctl.fs  <= FS_ADD;
        end else begin
            state <= next_state(state, bus.run, bus.IR[31:26]);
            ctl   <= decode(next_state(state, bus.run, bus.IR[31:26]), bus.IR, bus.SF);
        end
    end

    assign bus.AS      = ctl.asel;
    assign bus.PC_Sel  = ctl.pc_sel;
    assign bus.K_Sel   = ctl.k_sel;
    assign bus.IL      = ctl.il;
    assign bus.SL      = ctl.sl;
    assign bus.C0      = ctl.c0;
    assign bus.MW      = ctl.mw;
    assign bus.RW      = ctl.rw;
    assign bus.DS      = ctl.ds;
    assign bus.PS      = ctl.ps;
    assign bus.FS      = ctl.fs;
    assign bus.DA      = ctl.da;
    assign bus.SA      = ctl.sa;
    assign bus.SB      = ctl.sb;
    assign bus.halted  = ctl.halted;
    assign bus.illegal = ctl.illegal;
    assign bus.state   = state;
    assign bus.K       = {{48{bus.IR[15]}}, bus.IR[15:0]};

    logic unused_bits;
    assign unused_bits = ^{bus.IR[5:0], bus.SF};
endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller: one task per instruction class / scenario.
module tb_datapath_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    datapath_controller_if bus ();

    datapath_controller dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; bus.run = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // From IDLE, run the three edges that land in EXEC.
    task automatic to_exec(input logic [31:0] ir, input logic [3:0] sf);
        bus.IR = ir; bus.SF = sf; bus.run = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.run = 1'b0; bus.IR = 32'h0; bus.SF = 4'h0;
        tick(); tick();
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
        checks++; if ({bus.RW, bus.MW, bus.IL, bus.SL} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b want 0000", {bus.RW, bus.MW, bus.IL, bus.SL}); end
        checks++; if ({bus.halted, bus.illegal} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {bus.halted, bus.illegal}); end
        rst = 1'b0;
        tick();
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL idle_hold got %0d want 0", bus.state); end
    endtask

    task automatic test_addi;
        do_reset();
        bus.IR = 32'h0422_1234; bus.SF = 4'h0; bus.run = 1'b1;
        tick();
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL addi_fetch_state got %0d want 1", bus.state); end
        checks++; if ({bus.AS, bus.IL, bus.DS, bus.PS} !== 6'b11_11_00) begin errors++; $display("FAIL addi_fetch_ctl got %b want 111100", {bus.AS, bus.IL, bus.DS, bus.PS}); end
        tick();
        checks++; if (bus.state !== 3'd2 || bus.PS !== 2'b01) begin errors++; $display("FAIL addi_decode got st=%0d ps=%0d want st=2 ps=1", bus.state, bus.PS); end
        tick();
        checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL addi_exec_state got %0d want 3", bus.state); end
        checks++; if ({bus.RW, bus.K_Sel, bus.SL, bus.MW} !== 4'b1110) begin errors++; $display("FAIL addi_exec_ctl got %b want 1110", {bus.RW, bus.K_Sel, bus.SL, bus.MW}); end
        checks++; if (bus.DA !== 5'd1 || bus.SA !== 5'd2 || bus.FS !== 5'b01000) begin errors++; $display("FAIL addi_regs got da=%0d sa=%0d fs=%0h want 1 2 8", bus.DA, bus.SA, bus.FS); end
        checks++; if (bus.K !== 64'h1234) begin errors++; $display("FAIL addi_k got %0h want 1234", bus.K); end
        tick();
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL addi_next got %0d want 1", bus.state); end
    endtask

    task automatic test_alu_reg;
        do_reset();
        to_exec({6'd0, 5'd3, 5'd4, 5'd5, 5'h0A, 6'd0}, 4'h0);
        checks++; if (bus.FS !== 5'h0A || bus.SB !== 5'd5 || bus.DA !== 5'd3) begin errors++; $display("FAIL alu_fields got fs=%0h sb=%0d da=%0d want a 5 3", bus.FS, bus.SB, bus.DA); end
        checks++; if ({bus.RW, bus.SL, bus.K_Sel} !== 3'b110) begin errors++; $display("FAIL alu_ctl got %b want 110", {bus.RW, bus.SL, bus.K_Sel}); end
    endtask

    task automatic test_ldr;
        do_reset();
        to_exec(32'h08A3_FFFC, 4'h0);
        checks++; if ({bus.RW, bus.AS, bus.K_Sel, bus.DS} !== 5'b00111) begin errors++; $display("FAIL ldr_exec_ctl got %b want 00111", {bus.RW, bus.AS, bus.K_Sel, bus.DS}); end
        checks++; if (bus.K !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL ldr_k got %0h want fffffffffffffffc", bus.K); end
        tick();
        checks++; if (bus.state !== 3'd4 || bus.RW !== 1'b1 || bus.DA !== 5'd5) begin errors++; $display("FAIL ldr_mem got st=%0d rw=%b da=%0d want 4 1 5", bus.state, bus.RW, bus.DA); end
        checks++; if (bus.DS !== 2'b11 || bus.K_Sel !== 1'b1) begin errors++; $display("FAIL ldr_mem_ctl got ds=%b ks=%b want 11 1", bus.DS, bus.K_Sel); end
        tick();
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL ldr_next got %0d want 1", bus.state); end
    endtask

    task automatic test_str;
        do_reset();
        to_exec({6'd3, 5'd7, 5'd2, 5'd9, 11'h010}, 4'h0);
        checks++; if ({bus.MW, bus.RW, bus.DS, bus.AS} !== 5'b10100) begin errors++; $display("FAIL str_ctl got %b want 10100", {bus.MW, bus.RW, bus.DS, bus.AS}); end
        checks++; if (bus.SB !== 5'd7 || bus.SA !== 5'd2) begin errors++; $display("FAIL str_regs got sb=%0d sa=%0d want 7 2", bus.SB, bus.SA); end
    endtask

    task automatic test_branches;
        do_reset();
        to_exec({6'd5, 26'd0}, 4'b0010);
        checks++; if (bus.PS !== 2'b11 || bus.PC_Sel !== 1'b1) begin errors++; $display("FAIL beq_taken got ps=%b pcsel=%b want 11 1", bus.PS, bus.PC_Sel); end
        checks++; if ({bus.RW, bus.MW, bus.IL, bus.SL} !== 4'b0) begin errors++; $display("FAIL beq_strobes got %b want 0000", {bus.RW, bus.MW, bus.IL, bus.SL}); end
        do_reset();
        to_exec({6'd5, 26'd0}, 4'b1101);
        checks++; if (bus.PS !== 2'b00 || bus.PC_Sel !== 1'b1) begin errors++; $display("FAIL beq_not_taken got ps=%b pcsel=%b want 00 1", bus.PS, bus.PC_Sel); end
        do_reset();
        to_exec({6'd4, 26'd0}, 4'b0000);
        checks++; if (bus.PS !== 2'b11 || bus.PC_Sel !== 1'b1) begin errors++; $display("FAIL b_uncond got ps=%b pcsel=%b want 11 1", bus.PS, bus.PC_Sel); end
        do_reset();
        to_exec({6'd6, 5'd0, 5'd9, 16'd0}, 4'b0000);
        checks++; if (bus.PS !== 2'b10 || bus.PC_Sel !== 1'b0 || bus.SA !== 5'd9) begin errors++; $display("FAIL br got ps=%b pcsel=%b sa=%0d want 10 0 9", bus.PS, bus.PC_Sel, bus.SA); end
    endtask

    task automatic test_halt;
        do_reset();
        to_exec(32'hFC00_0000, 4'h0);
        tick();
        checks++; if (bus.state !== 3'd5 || bus.halted !== 1'b1) begin errors++; $display("FAIL halt_enter got st=%0d halted=%b want 5 1", bus.state, bus.halted); end
        bus.run = 1'b0; tick(); tick();
        bus.run = 1'b1; tick(); tick();
        checks++; if (bus.state !== 3'd5 || {bus.RW, bus.MW, bus.IL, bus.SL} !== 4'b0) begin errors++; $display("FAIL halt_hold got st=%0d strobes=%b want 5 0000", bus.state, {bus.RW, bus.MW, bus.IL, bus.SL}); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.state !== 3'd0 || bus.halted !== 1'b0) begin errors++; $display("FAIL halt_reset got st=%0d halted=%b want 0 0", bus.state, bus.halted); end
    endtask

    task automatic test_illegal;
        do_reset();
        to_exec({6'h2A, 26'd0}, 4'h0);
        checks++; if (bus.illegal !== 1'b1 || bus.RW !== 1'b0 || bus.MW !== 1'b0) begin errors++; $display("FAIL illegal_pulse got ill=%b rw=%b mw=%b want 1 0 0", bus.illegal, bus.RW, bus.MW); end
        tick();
        checks++; if (bus.illegal !== 1'b0 || bus.state !== 3'd1) begin errors++; $display("FAIL illegal_after got ill=%b st=%0d want 0 1", bus.illegal, bus.state); end
    endtask

    task automatic test_run_drop;
        do_reset();
        bus.IR = 32'h0422_1234; bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        tick();
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL drop_decode got %0d want 2", bus.state); end
        tick();
        checks++; if (bus.state !== 3'd0 || bus.RW !== 1'b0) begin errors++; $display("FAIL drop_idle got st=%0d rw=%b want 0 0", bus.state, bus.RW); end
        do_reset();
        to_exec(32'h08A3_FFFC, 4'h0);
        bus.run = 1'b0;
        tick();
        checks++; if (bus.state !== 3'd4 || bus.RW !== 1'b1) begin errors++; $display("FAIL drop_mem got st=%0d rw=%b want 4 1", bus.state, bus.RW); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        to_exec(32'h08A3_FFFC, 4'h0);
        tick();
        checks++; if (bus.state !== 3'd4 || bus.RW !== 1'b1) begin errors++; $display("FAIL mid_mem got st=%0d rw=%b want 4 1", bus.state, bus.RW); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.state !== 3'd0 || bus.RW !== 1'b0) begin errors++; $display("FAIL mid_reset got st=%0d rw=%b want 0 0", bus.state, bus.RW); end
        tick();
        checks++; if ({bus.RW, bus.MW, bus.IL, bus.SL} !== 4'b0) begin errors++; $display("FAIL mid_reset_hold got %b want 0000", {bus.RW, bus.MW, bus.IL, bus.SL}); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_alu_reg();
        test_ldr();
        test_str();
        test_branches();
        test_halt();
        test_illegal();
        test_run_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
